// File: rtl/router_serial_pkg.sv
// Definitions shared by the token-router serial transmitter and receiver:
// frame geometry, line levels and the FSM encodings of both ends.
package router_serial_pkg;

  localparam int DATA_W = 55;
  localparam int CNT_W  = 6;

  localparam logic LINE_IDLE  = 1'b0;
  localparam logic LINE_START = 1'b1;

  typedef enum logic {
    IDLE,
    SHIFT
  } rx_state_t;

  // Transmitter sequencing: idle low, one start bit, then DATA_W bits MSB first.
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA
  } tx_state_t;

endpackage

// File: rtl/rx_hold_buffer.sv
// Single-entry valid/ready holding register for received frames; a frame that
// completes while the entry is occupied and not being drained is dropped.
module rx_hold_buffer #(
  parameter int DATA_W = 55
) (
  input  logic              Clk_S,
  input  logic              Rst_n,
  input  logic [DATA_W-1:0] frame,
  input  logic              load,
  input  logic              RX_Ready,
  output logic [DATA_W-1:0] RX_Data,
  output logic              RX_Data_Valid,
  output logic              RX_Overrun
);

  logic accept;

  // A draining entry counts as free, so a same-edge load replaces it without a bubble.
  assign accept = !RX_Data_Valid || RX_Ready;

  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      RX_Data       <= '0;
      RX_Data_Valid <= 1'b0;
      RX_Overrun    <= 1'b0;
    end else begin
      RX_Overrun <= 1'b0;
      if (load) begin
        if (accept) begin
          RX_Data       <= frame;
          RX_Data_Valid <= 1'b1;
        end else begin
          RX_Overrun <= 1'b1;
        end
      end else if (RX_Data_Valid && RX_Ready) begin
        RX_Data_Valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_frame_receiver.sv
// Deserializer for the token-router serial link: detects the start bit, shifts
// in DATA_W bits MSB first and hands each frame to the holding register.
module serial_frame_receiver #(
  parameter int DATA_W = router_serial_pkg::DATA_W,
  parameter int CNT_W  = router_serial_pkg::CNT_W
) (
  input  logic              Clk_S,
  input  logic              Rst_n,
  input  logic              S_Data,
  output logic [DATA_W-1:0] RX_Data,
  output logic              RX_Data_Valid,
  input  logic              RX_Ready,
  output logic              RX_Busy,
  output logic              RX_Overrun
);

  import router_serial_pkg::*;

  rx_state_t         state;
  rx_state_t         next_state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-2:0] shift_reg;
  logic [DATA_W-1:0] frame;
  logic              load;

  // The final bit goes straight from the line into the holding register on the
  // completion edge, so the shift register only needs to hold DATA_W-1 bits.
  assign frame   = {shift_reg, S_Data};
  assign load    = (state == SHIFT) && (cnt == '0);
  assign RX_Busy = (state == SHIFT);

  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (S_Data == LINE_START) next_state = SHIFT;
      SHIFT:   if (cnt == '0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt       <= '0;
      shift_reg <= '0;
    end else if (state == IDLE) begin
      if (S_Data == LINE_START) begin
        cnt       <= CNT_W'(DATA_W - 1);
        shift_reg <= '0;
      end
    end else begin
      shift_reg <= frame[DATA_W-2:0];
      if (cnt != '0) cnt <= cnt - CNT_W'(1);
    end
  end

  rx_hold_buffer #(
    .DATA_W(DATA_W)
  ) u_hold (
    .Clk_S        (Clk_S),
    .Rst_n        (Rst_n),
    .frame        (frame),
    .load         (load),
    .RX_Ready     (RX_Ready),
    .RX_Data      (RX_Data),
    .RX_Data_Valid(RX_Data_Valid),
    .RX_Overrun   (RX_Overrun)
  );

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver; accepted frames go into a scoreboard
// queue and are compared when the DUT hands them over on a valid/ready edge.
module tb_serial_frame_receiver;

  localparam int DATA_W = 55;
  localparam int CNT_W  = 6;

  logic              Clk_S;
  logic              Rst_n;
  logic              S_Data;
  logic [DATA_W-1:0] RX_Data;
  logic              RX_Data_Valid;
  logic              RX_Ready;
  logic              RX_Busy;
  logic              RX_Overrun;

  logic [DATA_W-1:0] sb[$];
  int                xfer_cycles[$];
  int                passed;
  int                failed;
  int                total;
  int                cycle;
  int                ovr_count;

  serial_frame_receiver #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .Clk_S        (Clk_S),
    .Rst_n        (Rst_n),
    .S_Data       (S_Data),
    .RX_Data      (RX_Data),
    .RX_Data_Valid(RX_Data_Valid),
    .RX_Ready     (RX_Ready),
    .RX_Busy      (RX_Busy),
    .RX_Overrun   (RX_Overrun)
  );

  initial begin
    Clk_S = 1'b0;
    forever #5 Clk_S = ~Clk_S;
  end

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    logic              xfer;
    logic [DATA_W-1:0] held;
    logic [DATA_W-1:0] exp_frame;
    xfer = RX_Data_Valid && RX_Ready;
    held = RX_Data;
    @(posedge Clk_S);
    #1;
    cycle++;
    if (xfer) begin
      xfer_cycles.push_back(cycle);
      if (sb.size() == 0) begin
        check_output("xfer_unexpected", 64'(held), 64'hDEAD);
      end else begin
        exp_frame = sb.pop_front();
        check_output("xfer_data", 64'(held), 64'(exp_frame));
      end
    end
    if (RX_Overrun === 1'b1) ovr_count++;
  endtask

  // Start bit then DATA_W bits MSB first; RX_Ready is raised while driving bit raise_at.
  task automatic send_frame(input logic [DATA_W-1:0] data, input int raise_at);
    logic busy_ok;
    busy_ok = 1'b1;
    S_Data = 1'b1;
    tick();
    if (RX_Busy !== 1'b1) busy_ok = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      S_Data = data[i];
      if (i == raise_at) RX_Ready = 1'b1;
      tick();
      if (i != 0 && RX_Busy !== 1'b1) busy_ok = 1'b0;
    end
    S_Data = 1'b0;
    check_output("busy_during_frame", 64'(busy_ok), 64'd1);
    check_output("busy_after_frame", 64'(RX_Busy), 64'd0);
  endtask

  initial begin
    logic [DATA_W-1:0] frame_a;
    logic [DATA_W-1:0] frame_b;
    logic [DATA_W-1:0] ones;
    int                ovr_before;
    int                first_xfer;

    passed = 0;
    failed = 0;
    total = 0;
    cycle = 0;
    ovr_count = 0;
    ones = '1;
    S_Data = 1'b0;
    RX_Ready = 1'b0;
    Rst_n = 1'b0;

    // Reset state
    #1;
    check_output("rst_data", 64'(RX_Data), 64'd0);
    check_output("rst_valid", 64'(RX_Data_Valid), 64'd0);
    check_output("rst_busy", 64'(RX_Busy), 64'd0);
    check_output("rst_overrun", 64'(RX_Overrun), 64'd0);
    repeat (3) @(posedge Clk_S);
    #1;
    Rst_n = 1'b1;
    repeat (2) tick();

    // Single frame, consumer always ready: valid for exactly one cycle
    RX_Ready = 1'b1;
    frame_a = 55'h55AA33CC0F0F0F;
    sb.push_back(frame_a);
    send_frame(frame_a, -1);
    check_output("t1_valid", 64'(RX_Data_Valid), 64'd1);
    check_output("t1_data", 64'(RX_Data), 64'(frame_a));
    tick();
    check_output("t1_valid_cleared", 64'(RX_Data_Valid), 64'd0);
    check_output("t1_sb_empty", 64'(sb.size()), 64'd0);

    // Back-to-back frames with no idle gap
    ovr_before = ovr_count;
    xfer_cycles.delete();
    sb.push_back(ones);
    sb.push_back(55'h1);
    send_frame(ones, -1);
    check_output("t2_first_data", 64'(RX_Data), 64'(ones));
    send_frame(55'h1, -1);
    check_output("t2_second_data", 64'(RX_Data), 64'd1);
    check_output("t2_second_valid", 64'(RX_Data_Valid), 64'd1);
    tick();
    check_output("t2_xfer_count", 64'(xfer_cycles.size()), 64'd2);
    if (xfer_cycles.size() == 2) begin
      first_xfer = xfer_cycles[0];
      check_output("t2_spacing", 64'(xfer_cycles[1] - first_xfer), 64'd56);
    end
    check_output("t2_no_overrun", 64'(ovr_count - ovr_before), 64'd0);

    // Consumer stalled: A held, B dropped with a single overrun pulse
    RX_Ready = 1'b0;
    ovr_before = ovr_count;
    frame_a = 55'h12_3456_789A_BCDE;
    frame_b = 55'h6E_DCBA_9876_5432;
    sb.push_back(frame_a);
    send_frame(frame_a, -1);
    repeat (3) tick();
    send_frame(frame_b, -1);
    check_output("t3_overrun_pulse", 64'(RX_Overrun), 64'd1);
    check_output("t3_data_held", 64'(RX_Data), 64'(frame_a));
    check_output("t3_valid_held", 64'(RX_Data_Valid), 64'd1);
    tick();
    check_output("t3_overrun_one_cycle", 64'(RX_Overrun), 64'd0);
    check_output("t3_data_still_held", 64'(RX_Data), 64'(frame_a));
    RX_Ready = 1'b1;
    tick();
    check_output("t3_valid_cleared", 64'(RX_Data_Valid), 64'd0);
    check_output("t3_overrun_count", 64'(ovr_count - ovr_before), 64'd1);
    check_output("t3_sb_empty", 64'(sb.size()), 64'd0);

    // Ready rises on the edge B completes: A drains, B loads, no bubble
    RX_Ready = 1'b0;
    ovr_before = ovr_count;
    frame_a = 55'h0A_5A5A_5A5A_5A5A;
    frame_b = 55'h35_A5A5_A5A5_A5A5;
    sb.push_back(frame_a);
    send_frame(frame_a, -1);
    tick();
    sb.push_back(frame_b);
    send_frame(frame_b, 0);
    check_output("t4_valid_stays", 64'(RX_Data_Valid), 64'd1);
    check_output("t4_data_b", 64'(RX_Data), 64'(frame_b));
    check_output("t4_no_overrun", 64'(ovr_count - ovr_before), 64'd0);
    tick();
    check_output("t4_valid_cleared", 64'(RX_Data_Valid), 64'd0);
    check_output("t4_sb_empty", 64'(sb.size()), 64'd0);

    // Reset while bit 30 is being shifted, then a clean all-zero frame
    S_Data = 1'b1;
    tick();
    for (int i = DATA_W - 1; i >= 30; i--) begin
      S_Data = 1'b1;
      tick();
    end
    Rst_n = 1'b0;
    #1;
    check_output("t5_busy_in_reset", 64'(RX_Busy), 64'd0);
    check_output("t5_valid_in_reset", 64'(RX_Data_Valid), 64'd0);
    tick();
    tick();
    S_Data = 1'b0;
    Rst_n = 1'b1;
    repeat (3) tick();
    check_output("t5_idle_after_release", 64'(RX_Busy), 64'd0);
    check_output("t5_no_residue_valid", 64'(RX_Data_Valid), 64'd0);
    sb.push_back('0);
    send_frame('0, -1);
    check_output("t5_valid", 64'(RX_Data_Valid), 64'd1);
    check_output("t5_data_zero", 64'(RX_Data), 64'd0);
    tick();
    check_output("t5_sb_empty", 64'(sb.size()), 64'd0);

    // Leading data ones right after the start bit must not restart the frame
    frame_a = 55'h7F_C012_3456_789A;
    sb.push_back(frame_a);
    send_frame(frame_a, -1);
    check_output("t6_data", 64'(RX_Data), 64'(frame_a));
    tick();
    tick();
    check_output("t6_sb_empty", 64'(sb.size()), 64'd0);
    check_output("t6_busy_idle", 64'(RX_Busy), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
